// File: rtl/instr_seq_pkg.sv
// instr_seq_pkg: shared constants and types for the instruction sequencer.
// miniCPU opcodes, FSM state encoding and the default idle word.
package instr_seq_pkg;

  localparam int DEPTH_DEF   = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int INSTR_W_DEF = 12;

  // miniCPU opcodes, In[11:8]
  localparam logic [3:0] OP_CLR = 4'b0000;
  localparam logic [3:0] OP_LD1 = 4'b0001;
  localparam logic [3:0] OP_LD2 = 4'b0010;
  localparam logic [3:0] OP_ST2 = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SHL = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0111;
  localparam logic [3:0] OP_OR  = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1001;
  localparam logic [3:0] OP_NOP = 4'b1111;

  // Reserved opcode 1111 is a miniCPU no-op; never all-zero (that is CLEAR).
  localparam logic [11:0] IDLE_WORD_DEF = {OP_NOP, 8'h00};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage

// File: rtl/instr_seq_mem.sv
// instr_seq_mem: program store, synchronous write, combinational read.
// Contents are intentionally not reset so programs survive a Reset pulse.
module instr_seq_mem #(
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 12
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0]  i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  logic [INSTR_W-1:0] r_mem [DEPTH];

  // Program write port
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: loadable, restartable program feed for miniCPU.In.
// Plays stored 12-bit words one per Clock; registered outputs.
// Optional macro OVF_HALT_EN: Overflow in RUN halts into a sticky HALT state.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int                 DEPTH     = DEPTH_DEF,
  parameter int                 ADDR_W    = ADDR_W_DEF,
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] IDLE_WORD = INSTR_W'(IDLE_WORD_DEF)
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               WrEn,
  input  logic [ADDR_W-1:0]  WrAddr,
  input  logic [INSTR_W-1:0] WrData,
  input  logic               Start,
  input  logic               Stop,
  input  logic [ADDR_W:0]    Length,
  input  logic               Loop,
  input  logic               Overflow,
  output logic [INSTR_W-1:0] InstrOut,
  output logic               InstrValid,
  output logic [ADDR_W-1:0]  PC,
  output logic               Busy,
  output logic               Done,
  output logic               Halted
);

  localparam int LEN_W = ADDR_W + 1;

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
  logic [LEN_W-1:0]   r_len, w_len_nxt;
  logic               r_loop, w_loop_nxt;
  logic [INSTR_W-1:0] r_instr, w_instr_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_busy;
  logic               r_done, w_done_nxt;
  logic               r_halted, w_halted_nxt;

  logic               w_we;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic [INSTR_W-1:0] w_mem_rd, w_rd_data;
  logic [LEN_W-1:0]   w_len_clamp;
  logic               w_issue;

`ifndef OVF_HALT_EN
  logic w_unused_ovf;
  assign w_unused_ovf = Overflow;
`endif

  // Program memory is frozen while a run is in flight
  assign w_we = WrEn && (r_state != RUN);

  instr_seq_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_mem (
    .i_clk  (Clock),
    .i_we   (w_we),
    .i_waddr(WrAddr),
    .i_wdata(WrData),
    .i_raddr(w_rd_addr),
    .o_rdata(w_mem_rd)
  );

  // A write landing on the same edge as Start must be seen by the first fetch
  assign w_rd_data   = (w_we && (WrAddr == w_rd_addr)) ? WrData : w_mem_rd;
  assign w_len_clamp = (Length > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : Length;

  // Next-state, next-PC and next-output decode
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_len_nxt    = r_len;
    w_loop_nxt   = r_loop;
    w_instr_nxt  = IDLE_WORD;
    w_valid_nxt  = 1'b0;
    w_done_nxt   = 1'b0;
    w_halted_nxt = r_halted;
    w_rd_addr    = '0;
    w_issue      = 1'b0;
    case (r_state)
      RUN: begin
        if (Stop) begin
          w_state_nxt = IDLE;
`ifdef OVF_HALT_EN
        end else if (Overflow) begin
          // PC keeps pointing at the last issued word
          w_state_nxt  = HALT;
          w_halted_nxt = 1'b1;
`endif
        end else if ({1'b0, r_pc} == r_len - LEN_W'(1)) begin
          if (r_loop) begin
            w_pc_nxt = '0;
            w_issue  = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_pc_nxt  = r_pc + ADDR_W'(1);
          w_rd_addr = r_pc + ADDR_W'(1);
          w_issue   = 1'b1;
        end
      end
      default: begin
        // IDLE and HALT both accept Start; Stop in the same cycle wins
        if (Start && !Stop) begin
          w_halted_nxt = 1'b0;
          if (w_len_clamp != '0) begin
            w_state_nxt = RUN;
            w_len_nxt   = w_len_clamp;
            w_loop_nxt  = Loop;
            w_pc_nxt    = '0;
            w_issue     = 1'b1;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
    endcase
    if (w_issue) begin
      w_instr_nxt = w_rd_data;
      w_valid_nxt = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Output and run-context registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_pc     <= '0;
      r_len    <= '0;
      r_loop   <= 1'b0;
      r_instr  <= IDLE_WORD;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_pc     <= w_pc_nxt;
      r_len    <= w_len_nxt;
      r_loop   <= w_loop_nxt;
      r_instr  <= w_instr_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= (w_state_nxt == RUN);
      r_done   <= w_done_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  assign InstrOut   = r_instr;
  assign InstrValid = r_valid;
  assign PC         = r_pc;
  assign Busy       = r_busy;
  assign Done       = r_done;
  assign Halted     = r_halted;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized self-checking bench for instr_sequencer.
// Reference model: an array copy of program memory; the expected stream of a
// run is ref_mem[i % min(Length,32)] for i = 0,1,2,...
module tb_instr_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        WrEn;
  logic [4:0]  WrAddr;
  logic [11:0] WrData;
  logic        Start;
  logic        Stop;
  logic [5:0]  Length;
  logic        Loop;
  logic        Overflow;
  logic [11:0] InstrOut;
  logic        InstrValid;
  logic [4:0]  PC;
  logic        Busy;
  logic        Done;
  logic        Halted;

  int n_chk = 0;
  int n_err = 0;
  logic [11:0] ref_mem [32];

  instr_sequencer dut (
    .Clock(Clock), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .Start(Start), .Stop(Stop), .Length(Length), .Loop(Loop), .Overflow(Overflow),
    .InstrOut(InstrOut), .InstrValid(InstrValid), .PC(PC), .Busy(Busy),
    .Done(Done), .Halted(Halted)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Program write while the sequencer is idle; model follows
  task automatic wr(input int a, input logic [11:0] d);
    WrEn = 1'b1; WrAddr = 5'(a); WrData = d;
    tick();
    WrEn = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_start(input int len, input bit loop, input bit wr0);
    Start = 1'b1; Length = 6'(len); Loop = loop;
    if (wr0) begin
      WrEn = 1'b1; WrAddr = 5'd0; WrData = 12'($urandom);
      ref_mem[0] = WrData;
    end
    tick();
    Start = 1'b0; WrEn = 1'b0;
  endtask

  task automatic wait_valid();
    int w = 0;
    while (!InstrValid && w < 3) begin
      tick();
      w++;
    end
    chk("first_valid", InstrValid, 1);
  endtask

  // Start a run and check n_obs issued words, then the ending
  task automatic run_chk(input int len, input bit loop, input int n_obs,
                         input bit do_stop, input bit wr_mid, input bit wr0,
                         input int ovf_at);
    int eff = (len > 32) ? 32 : len;
    do_start(len, loop, wr0);
    wait_valid();
    for (int i = 0; i < n_obs; i++) begin
      chk("pc", PC, i % eff);
      chk("word", InstrOut, ref_mem[i % eff]);
      chk("valid", InstrValid, 1);
      chk("busy", Busy, 1);
      chk("done_mid", Done, 0);
      chk("halted_run", Halted, 0);
      if (wr_mid && i == 0) begin
        WrEn = 1'b1; WrAddr = 5'd1; WrData = 12'h999;  // ignored while busy
      end
      if (i == ovf_at) Overflow = 1'b1;
      if (do_stop && i == n_obs - 1) Stop = 1'b1;
      tick();
      WrEn = 1'b0; Stop = 1'b0; Overflow = 1'b0;
    end
    chk("end_word", InstrOut, 12'hF00);
    chk("end_valid", InstrValid, 0);
    chk("end_busy", Busy, 0);
    chk("end_done", Done, (!do_stop && !loop) ? 1 : 0);
    tick();
    chk("done_pulse", Done, 0);
    chk("idle_valid", InstrValid, 0);
  endtask

  initial begin
    bit done_seen, valid_seen;
    Reset = 1'b1; WrEn = 0; WrAddr = 0; WrData = 0; Start = 0; Stop = 0;
    Length = 0; Loop = 0; Overflow = 0;
    tick(); tick();
    chk("rst_instr", InstrOut, 12'hF00);
    chk("rst_valid", InstrValid, 0);
    chk("rst_pc", PC, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_halted", Halted, 0);
    Reset = 1'b0;
    tick();

    for (int a = 0; a < 32; a++) wr(a, 12'($urandom));
    wr(0, 12'h180); wr(1, 12'h282); wr(2, 12'h400);

    // basic run, then looping run stopped on the second pass at PC=1
    run_chk(3, 0, 3, 0, 0, 0, -1);
    run_chk(3, 1, 5, 1, 0, 0, -1);

    // Length=0: Done only, nothing issued
    do_start(0, 0, 0);
    done_seen = 0; valid_seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (Done) done_seen = 1;
      if (InstrValid) valid_seen = 1;
      tick();
    end
    chk("len0_done", done_seen, 1);
    chk("len0_valid", valid_seen, 0);
    chk("len0_busy", Busy, 0);

    // Length clamped to DEPTH
    run_chk(40, 0, 32, 0, 0, 0, -1);

    // write during RUN is dropped; write in IDLE lands
    run_chk(3, 0, 3, 0, 1, 0, -1);
    run_chk(3, 0, 3, 0, 0, 0, -1);
    wr(1, 12'h999);
    run_chk(3, 0, 3, 0, 0, 0, -1);

    // write to address 0 in the same cycle as Start
    run_chk(3, 0, 3, 0, 0, 1, -1);

    // overflow handling
    wr(0, 12'h180); wr(1, 12'h282); wr(2, 12'h501); wr(3, 12'h700);
`ifdef OVF_HALT_EN
    do_start(4, 0, 0);
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      chk("ovf_pc", PC, i);
      chk("ovf_word", InstrOut, ref_mem[i]);
      if (i == 2) Overflow = 1'b1;
      tick();
    end
    Overflow = 1'b0;
    chk("halt_flag", Halted, 1);
    chk("halt_word", InstrOut, 12'hF00);
    chk("halt_valid", InstrValid, 0);
    chk("halt_pc", PC, 2);
    chk("halt_busy", Busy, 0);
    chk("halt_done", Done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_hold_valid", InstrValid, 0);
      chk("halt_hold_flag", Halted, 1);
    end
    run_chk(4, 0, 4, 0, 0, 0, -1);
`else
    run_chk(4, 0, 4, 0, 0, 0, 2);
`endif

    // asynchronous reset mid-run
    do_start(10, 1, 0);
    wait_valid();
    tick(); tick();
    #2 Reset = 1'b1;
    #1;
    chk("arst_instr", InstrOut, 12'hF00);
    chk("arst_busy", Busy, 0);
    chk("arst_valid", InstrValid, 0);
    chk("arst_pc", PC, 0);
    #1 Reset = 1'b0;
    tick();
    chk("arst_idle", Busy, 0);
    run_chk(4, 0, 4, 0, 0, 0, -1);

    // randomized programs and lengths
    for (int it = 0; it < 8; it++) begin
      int len;
      for (int k = 0; k < 4; k++) wr($urandom_range(0, 31), 12'($urandom));
      len = $urandom_range(1, 40);
      run_chk(len, 0, (len > 32) ? 32 : len, 0, 0, it[0], -1);
    end
    for (int it = 0; it < 4; it++) begin
      run_chk($urandom_range(1, 40), 1, $urandom_range(1, 70), 1, 0, 0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
